// File: rtl/imem_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch_ctrl_if
// Description : Fetch / ITCM / IAXI signal bundle for the instruction-memory
//               fetch controller. 'slave' is the controller's view and
//               'master' is the view of the surrounding fetch unit and memories.
// Revision    : 1.0 - initial release
// ============================================================================
interface imem_fetch_ctrl_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    // fetch side
    logic               fetch_req;
    logic [ADDR_W-1:0]  fetch_addr;
    logic               fetch_ready;
    logic               fetch_flush;
    logic [INSTR_W-1:0] instr_read_data;
    logic               instr_read_data_valid;
    logic               instr_read_err;
    // ITCM side
    logic               instr_itcm_access;
    logic [ADDR_W-1:0]  instr_itcm_addr;
    logic [INSTR_W-1:0] instr_itcm_read_data;
    logic               instr_itcm_read_data_valid;
    logic               itcm_auto_load;
    // IAXI side
    logic               IAXI_access;
    logic [ADDR_W-1:0]  IAXI_addr;
    logic               IAXI_ready;
    logic [INSTR_W-1:0] IAXI_read_data;
    logic               IAXI_read_data_valid;
    logic               IAXI_read_err;

    modport slave (
        input  fetch_req, fetch_addr, fetch_flush,
        output fetch_ready, instr_read_data, instr_read_data_valid, instr_read_err,
        output instr_itcm_access, instr_itcm_addr,
        input  instr_itcm_read_data, instr_itcm_read_data_valid, itcm_auto_load,
        output IAXI_access, IAXI_addr,
        input  IAXI_ready, IAXI_read_data, IAXI_read_data_valid, IAXI_read_err
    );

    modport master (
        output fetch_req, fetch_addr, fetch_flush,
        input  fetch_ready, instr_read_data, instr_read_data_valid, instr_read_err,
        input  instr_itcm_access, instr_itcm_addr,
        output instr_itcm_read_data, instr_itcm_read_data_valid, itcm_auto_load,
        input  IAXI_access, IAXI_addr,
        output IAXI_ready, IAXI_read_data, IAXI_read_data_valid, IAXI_read_err
    );
endinterface
`default_nettype wire

// File: rtl/imem_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : imem_fetch_ctrl
// Description : Instruction-memory fetch controller. Decodes each fetch to
//               ITCM, IAXI or an immediate misalignment error, tracks the
//               outstanding requests in an in-order tag queue and returns
//               responses to fetch in request order, discarding responses
//               that belong to requests issued before a flush.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_fetch_ctrl #(
    parameter int                ADDR_W    = 32,
    parameter int                INSTR_W   = 32,
    parameter int                HAS_ITCM  = 1,
    parameter logic [ADDR_W-1:0] ITCM_BASE = 32'h0000_0000,
    parameter logic [ADDR_W-1:0] ITCM_SIZE = 32'h0001_0000,
    parameter int                MAX_OUTS  = 4
) (
    input  logic               cpu_clk,
    input  logic               cpu_rst,
    imem_fetch_ctrl_if.slave   bus
);
    localparam int c_PTR_W = $clog2(MAX_OUTS);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0] c_FULL = c_CNT_W'(MAX_OUTS);
    // One extra bit so BASE+SIZE at the top of the address map cannot wrap.
    localparam logic [ADDR_W:0] c_ITCM_LO = {1'b0, ITCM_BASE};
    localparam logic [ADDR_W:0] c_ITCM_HI = {1'b0, ITCM_BASE} + {1'b0, ITCM_SIZE};

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_ITCM = 2'd1,
        SRC_AXI  = 2'd2,
        SRC_ERR  = 2'd3
    } src_t;

    src_t                r_q_src [MAX_OUTS];
    logic [MAX_OUTS-1:0] r_q_drop;
    logic [c_PTR_W-1:0]  r_wr_ptr;
    logic [c_PTR_W-1:0]  r_rd_ptr;
    logic [c_CNT_W-1:0]  r_count;
    src_t                r_last_src;

    src_t                w_src;
    logic [ADDR_W:0]     w_addr_ext;
    logic                w_in_itcm;
    logic                w_order_ok;
    logic                w_base_ok;
    logic                w_accept_cond;
    logic                w_ready;
    logic                w_push;
    logic                w_pop;
    logic                w_rsp_valid;
    src_t                w_head_src;
    logic                w_head_drop;
    logic [MAX_OUTS-1:0] w_drop_next;
    logic [INSTR_W-1:0]  w_rsp_data;
    logic                w_rsp_err;

    // Address decode, ordering and accept logic for the incoming fetch.
    always_comb begin
        w_addr_ext = {1'b0, bus.fetch_addr};
        w_in_itcm  = (w_addr_ext >= c_ITCM_LO) && (w_addr_ext < c_ITCM_HI);
        if (bus.fetch_addr[1:0] != 2'b00) begin
            w_src = SRC_ERR;
        end else if ((HAS_ITCM != 0) && w_in_itcm) begin
            w_src = SRC_ITCM;
        end else begin
            w_src = SRC_AXI;
        end
        // Switching source is only safe once everything older has returned,
        // since the two memories return data independently.
        w_order_ok    = (r_count == '0) || (w_src == r_last_src);
        w_base_ok     = !bus.itcm_auto_load && (r_count < c_FULL) && w_order_ok;
        w_accept_cond = bus.fetch_req && w_base_ok;
        w_ready       = w_base_ok && ((w_src != SRC_AXI) || bus.IAXI_ready);
        w_push        = bus.fetch_req && w_ready;
    end

    // Head-of-queue pop and response formatting.
    always_comb begin
        w_head_src  = r_q_src[r_rd_ptr];
        w_head_drop = r_q_drop[r_rd_ptr];
        w_pop       = 1'b0;
        if (r_count != '0) begin
            case (w_head_src)
                SRC_ITCM: w_pop = bus.instr_itcm_read_data_valid;
                SRC_AXI:  w_pop = bus.IAXI_read_data_valid && !bus.itcm_auto_load;
                SRC_ERR:  w_pop = 1'b1;
                default:  w_pop = 1'b0;
            endcase
        end
        // A flush in the popping cycle also discards the popping entry.
        w_rsp_valid = w_pop && !w_head_drop && !bus.fetch_flush;
        w_rsp_data  = '0;
        w_rsp_err   = 1'b0;
        if (w_rsp_valid) begin
            case (w_head_src)
                SRC_ITCM: w_rsp_data = bus.instr_itcm_read_data;
                SRC_AXI:  begin
                    w_rsp_data = bus.IAXI_read_data;
                    w_rsp_err  = bus.IAXI_read_err;
                end
                SRC_ERR:  w_rsp_err = 1'b1;
                default:  w_rsp_data = '0;
            endcase
        end
    end

    // Next drop vector: flush marks all slots, a new push starts clean.
    always_comb begin
        w_drop_next = r_q_drop;
        if (bus.fetch_flush) begin
            w_drop_next = '1;
        end
        if (w_push) begin
            w_drop_next[r_wr_ptr] = 1'b0;
        end
    end

    // Tag queue state: entries, pointers, occupancy and youngest source.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            for (int i = 0; i < MAX_OUTS; i++) begin
                r_q_src[i] <= SRC_NONE;
            end
            r_q_drop   <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_last_src <= SRC_NONE;
        end else begin
            r_q_drop <= w_drop_next;
            if (w_push) begin
                r_q_src[r_wr_ptr] <= w_src;
                r_wr_ptr          <= r_wr_ptr + c_PTR_W'(1);
                r_last_src        <= w_src;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.fetch_ready           = w_ready;
    assign bus.instr_itcm_access     = w_accept_cond && (w_src == SRC_ITCM);
    assign bus.instr_itcm_addr       = bus.fetch_addr;
    assign bus.IAXI_access           = w_accept_cond && (w_src == SRC_AXI);
    assign bus.IAXI_addr             = bus.fetch_addr;
    assign bus.instr_read_data       = w_rsp_data;
    assign bus.instr_read_data_valid = w_rsp_valid;
    assign bus.instr_read_err        = w_rsp_err;

endmodule
`default_nettype wire
